bcd_score_keeper: RTL

Parametrised multi-digit BCD score register for the game datapath, the successor to the fixed two-digit score counter. It adds a variable BCD increment (0–9 points per event), decrement, selectable saturate or wrap at the top, and a retained high-score register with event flags. It sits between the game-logic event strobes and the seven-segment/VGA score display, which consume `score` and `high_score` as packed BCD digits.

---
 rtl/score_pkg.sv | 14 +
 rtl/bcd_digit_addsub.sv | 41 ++++
 rtl/bcd_score_keeper.sv | 106 ++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and helpers for the BCD score keeper.
// Digit-level constants and the increment clamp.
package score_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  function automatic bcd_digit_t bcd_sat_amt(input logic [3:0] a);
    return (a > BCD_MAX) ? BCD_MAX : a;
  endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit of the score datapath.
// mode 0 adds amt+cin, mode 1 subtracts amt+cin (cin is the borrow).
module bcd_digit_addsub
  import score_pkg::*;
(
  input  bcd_digit_t digit,
  input  bcd_digit_t amt,
  input  logic       cin,
  input  logic       mode,
  output bcd_digit_t dout,
  output logic       cout
);

  logic [4:0] sum;
  logic [3:0] need;

  assign sum  = {1'b0, digit} + {1'b0, amt} + {4'd0, cin};
  assign need = amt + {3'd0, cin};

  // Decimal-adjusted add or borrow-ripple subtract for one digit
  always_comb begin
    dout = digit;
    cout = 1'b0;
    if (!mode) begin
      if (sum > 5'd9) begin
        dout = sum[3:0] + 4'd6;
        cout = 1'b1;
      end else begin
        dout = sum[3:0];
      end
    end else begin
      if (digit < need) begin
        dout = digit + 4'd10 - need;
        cout = 1'b1;
      end else begin
        dout = digit - need;
      end
    end
  end

endmodule

// File: rtl/bcd_score_keeper.sv
// Multi-digit BCD score register with high-score tracking.
// Ripple BCD inc/dec, saturate or wrap at the top, registered flags.
module bcd_score_keeper
  import score_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              hs_clr,
  input  logic              inc,
  input  logic [3:0]        inc_amt,
  input  logic              dec,
  output logic [4*NDIG-1:0] score,
  output logic [4*NDIG-1:0] high_score,
  output logic              ovf,
  output logic              new_high
);

  localparam int W = 4 * NDIG;
  localparam logic [W-1:0] ALL9 = {NDIG{BCD_MAX}};

  logic [W-1:0] score_q;
  logic [W-1:0] hs_q;
  logic         ovf_q;
  logic         nh_q;

  logic [W-1:0] sum;
  logic [W-1:0] score_next;
  logic [NDIG:0] cy;
  logic         do_inc;
  logic         do_dec;
  logic         sub;
  logic         ovf_next;
  logic         raise;
  bcd_digit_t   amt0;

  assign do_inc = inc & ~dec & ~clr;
  assign do_dec = dec & ~inc & ~clr & (score_q != '0);
  assign sub    = ~do_inc;
  assign amt0   = do_inc ? bcd_sat_amt(inc_amt) : BCD_ZERO;
  assign cy[0]  = sub;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit_addsub u_dig (
      .digit (score_q[4*g +: 4]),
      .amt   ((g == 0) ? amt0 : BCD_ZERO),
      .cin   (cy[g]),
      .mode  (sub),
      .dout  (sum[4*g +: 4]),
      .cout  (cy[g+1])
    );
  end

  // Operation priority and saturate/wrap selection
  always_comb begin
    score_next = score_q;
    ovf_next   = 1'b0;
    if (clr) begin
      score_next = '0;
    end else if (do_inc) begin
      if (cy[NDIG]) begin
        ovf_next   = 1'b1;
        score_next = SATURATE ? ALL9 : sum;
      end else begin
        score_next = sum;
      end
    end else if (do_dec) begin
      score_next = sum;
    end
  end

  // Raise only when the score actually moves, so a cleared high score
  // stays cleared until the next scoring event.
  always_comb begin
    raise = ~hs_clr
          & (score_next != score_q)
          & (score_next > hs_q);
  end

  // State and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
      hs_q    <= '0;
      ovf_q   <= 1'b0;
      nh_q    <= 1'b0;
    end else begin
      score_q <= score_next;
      ovf_q   <= ovf_next;
      nh_q    <= raise;
      if (hs_clr)
        hs_q <= '0;
      else if (raise)
        hs_q <= score_next;
    end
  end

  assign score      = score_q;
  assign high_score = hs_q;
  assign ovf        = ovf_q;
  assign new_high   = nh_q;

endmodule
